// File: rtl/wb_register_file.sv
// -----------------------------------------------------------------------------
// wb_register_file
// Write-back stage of the pipeline. It selects the write-back value from the
// latched MEM/WB fields and commits it into an NREGS x XLEN architectural
// register file. Two combinational read ports serve the decode stage. When a
// read hits the register being written this cycle, the read returns the new
// value without waiting a cycle. A counter tracks how many register writes
// have been committed.
//
// Ports
//   Clk           in   rising-edge clock
//   RstN          in   asynchronous active-low reset (clears array + counter)
//   IWB[1:0]      in   [0]=RegWrite, [1]=MemToReg
//   IDataMemory   in   loaded word
//   IAlu          in   ALU result
//   IInstruction  in   destination register index
//   IReadAddr1/2  in   read port indices
//   OReadData1/2  out  read port data (combinational, write-through bypass)
//   OWriteData    out  selected write-back value (combinational)
//   OWriteEn      out  effective write enable this cycle (combinational)
//   OWriteCount   out  committed writes since reset, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module wb_register_file #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [1:0]       IWB,
    input  logic [XLEN-1:0]  IDataMemory,
    input  logic [XLEN-1:0]  IAlu,
    input  logic [4:0]       IInstruction,
    input  logic [4:0]       IReadAddr1,
    input  logic [4:0]       IReadAddr2,
    output logic [XLEN-1:0]  OReadData1,
    output logic [XLEN-1:0]  OReadData2,
    output logic [XLEN-1:0]  OWriteData,
    output logic             OWriteEn,
    output logic [CNT_W-1:0] OWriteCount
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic [XLEN-1:0]  write_data;
    logic             write_en;

    // Write-back select and effective enable. RstN is part of the enable so
    // that nothing is bypassed to the readers while reset is held.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // the values just computed. Clocked blocks use '<=' instead.
        write_data = IWB[1] ? IDataMemory : IAlu;
        write_en   = RstN & IWB[0] & ~(ZERO_EN && (IInstruction == 5'd0));
    end

    // Next-state for the array and the counter.
    always_comb begin
        // NOTE: every variable gets its default before any conditional write.
        // Without that default, a path that skips the write infers a latch.
        regs_d  = regs_q;
        count_d = count_q;
        if (write_en) begin
            regs_d[IInstruction] = write_data;
            count_d              = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            // NOTE: this array is reset on purpose. Its contents must read as
            // zero right after reset. For large RAMs you would normally leave
            // the array without a reset so it can map onto memory macros.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    // Read ports. Register 0 is forced to zero when ZERO_EN is set. A read that
    // matches the index being written this cycle returns the new value.
    always_comb begin
        OReadData1 = regs_q[IReadAddr1];
        if (ZERO_EN && (IReadAddr1 == 5'd0)) begin
            OReadData1 = '0;
        end else if (write_en && (IReadAddr1 == IInstruction)) begin
            OReadData1 = write_data;
        end

        OReadData2 = regs_q[IReadAddr2];
        if (ZERO_EN && (IReadAddr2 == 5'd0)) begin
            OReadData2 = '0;
        end else if (write_en && (IReadAddr2 == IInstruction)) begin
            OReadData2 = write_data;
        end
    end

    assign OWriteData  = write_data;
    assign OWriteEn    = write_en;
    assign OWriteCount = count_q;

    // An unknown control word outside reset is a bug upstream.
    a_wb_known: assert property (@(posedge Clk) disable iff (!RstN) !$isunknown(IWB))
        else $error("wb_register_file: IWB is unknown");

endmodule

// File: tb/tb_wb_register_file.sv
module tb_wb_register_file;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        s_rst_n = 1'b0;
    logic [1:0]  IWB = 2'b00;
    logic [63:0] IDataMemory = '0;
    logic [63:0] IAlu = '0;
    logic [4:0]  IInstruction = '0;
    logic [4:0]  IReadAddr1 = '0;
    logic [4:0]  IReadAddr2 = '0;

    logic [63:0] OReadData1, OReadData2, OWriteData;
    logic        OWriteEn;
    logic [31:0] OWriteCount;

    // Small instance: register 0 is ordinary and the counter is 3 bits wide,
    // so a wrap takes only 8 writes.
    logic [63:0] s_rd1, s_rd2, s_wd;
    logic        s_we;
    logic [2:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    wb_register_file dut (
        .Clk(Clk), .RstN(RstN), .IWB(IWB), .IDataMemory(IDataMemory), .IAlu(IAlu),
        .IInstruction(IInstruction), .IReadAddr1(IReadAddr1), .IReadAddr2(IReadAddr2),
        .OReadData1(OReadData1), .OReadData2(OReadData2), .OWriteData(OWriteData),
        .OWriteEn(OWriteEn), .OWriteCount(OWriteCount)
    );

    wb_register_file #(.ZERO_REG(0), .CNT_W(3)) u_small (
        .Clk(Clk), .RstN(s_rst_n), .IWB(IWB), .IDataMemory(IDataMemory), .IAlu(IAlu),
        .IInstruction(IInstruction), .IReadAddr1(IReadAddr1), .IReadAddr2(IReadAddr2),
        .OReadData1(s_rd1), .OReadData2(s_rd2), .OWriteData(s_wd),
        .OWriteEn(s_we), .OWriteCount(s_cnt)
    );

    task automatic drive(input logic [1:0] wb, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] mem);
        IWB = wb; IInstruction = rd; IAlu = alu; IDataMemory = mem;
    endtask

    // Advance through one rising edge and land on the next falling edge.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        @(negedge Clk);
        drive(2'b01, 5'd5, 64'h1234, 64'h0);
        IReadAddr1 = 5'd5;
        #1;
        checks++;
        if (OWriteEn !== 1'b0) begin
            errors++; $display("FAIL reset_we got %0b want 0", OWriteEn);
        end
        checks++;
        if (OWriteCount !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0h want 0", OWriteCount);
        end
        checks++;
        if (OReadData1 !== 64'd0) begin
            errors++; $display("FAIL reset_nobypass got %0h want 0", OReadData1);
        end
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        for (int i = 0; i < 32; i++) begin
            IReadAddr1 = 5'(i);
            IReadAddr2 = 5'(31 - i);
            #1;
            checks++;
            if (OReadData1 !== 64'd0 || OReadData2 !== 64'd0) begin
                errors++;
                $display("FAIL reset_reg%0d got %0h/%0h want 0/0", i, OReadData1, OReadData2);
            end
        end
        checks++;
        if (s_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_small_cnt got %0d want 0", s_cnt);
        end
        @(negedge Clk);
        RstN = 1'b1;
    endtask

    task automatic test_alu_write();
        drive(2'b01, 5'd5, 64'h0123_4567_89AB_CDEF, 64'hFFFF);
        IReadAddr1 = 5'd5;
        #1;
        checks++;
        if (OWriteEn !== 1'b1 || OWriteData !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL alu_wd got %0b/%0h want 1/0123456789abcdef", OWriteEn, OWriteData);
        end
        step();
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        #1;
        checks++;
        if (OReadData1 !== 64'h0123_4567_89AB_CDEF) begin
            errors++; $display("FAIL alu_reg5 got %0h want 0123456789abcdef", OReadData1);
        end
        checks++;
        if (OWriteCount !== 32'd1) begin
            errors++; $display("FAIL alu_cnt got %0d want 1", OWriteCount);
        end
    endtask

    task automatic test_load_write();
        @(negedge Clk);
        drive(2'b11, 5'd7, 64'h1, 64'hDEAD_BEEF_0000_0001);
        #1;
        checks++;
        if (OWriteData !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL load_wd got %0h want deadbeef00000001", OWriteData);
        end
        step();
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        IReadAddr2 = 5'd7;
        #1;
        checks++;
        if (OReadData2 !== 64'hDEAD_BEEF_0000_0001) begin
            errors++; $display("FAIL load_reg7 got %0h want deadbeef00000001", OReadData2);
        end
        checks++;
        if (OWriteCount !== 32'd2) begin
            errors++; $display("FAIL load_cnt got %0d want 2", OWriteCount);
        end
    endtask

    task automatic test_bypass();
        @(negedge Clk);
        drive(2'b01, 5'd9, 64'hAA, 64'h0);
        step();
        drive(2'b01, 5'd9, 64'h55, 64'h0);
        IReadAddr1 = 5'd9;
        IReadAddr2 = 5'd9;
        #1;
        checks++;
        if (OReadData1 !== 64'h55 || OReadData2 !== 64'h55) begin
            errors++; $display("FAIL bypass_same got %0h/%0h want 55/55", OReadData1, OReadData2);
        end
        step();
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        #1;
        checks++;
        if (OReadData1 !== 64'h55 || OWriteCount !== 32'd4) begin
            errors++; $display("FAIL bypass_after got %0h cnt %0d want 55 cnt 4", OReadData1, OWriteCount);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge Clk);
        drive(2'b01, 5'd0, 64'hFF, 64'h0);
        IReadAddr1 = 5'd0;
        #1;
        checks++;
        if (OWriteEn !== 1'b0 || OReadData1 !== 64'd0) begin
            errors++; $display("FAIL zero_bypass got we %0b data %0h want 0/0", OWriteEn, OReadData1);
        end
        step();
        checks++;
        if (OReadData1 !== 64'd0 || OWriteCount !== 32'd4) begin
            errors++; $display("FAIL zero_after got %0h cnt %0d want 0 cnt 4", OReadData1, OWriteCount);
        end
        drive(2'b00, 5'd3, 64'h123, 64'h456);
        IReadAddr1 = 5'd3;
        #1;
        checks++;
        if (OWriteEn !== 1'b0 || OReadData1 !== 64'd0) begin
            errors++; $display("FAIL disabled_bypass got we %0b data %0h want 0/0", OWriteEn, OReadData1);
        end
        step();
        checks++;
        if (OReadData1 !== 64'd0 || OWriteCount !== 32'd4) begin
            errors++; $display("FAIL disabled_after got %0h cnt %0d want 0 cnt 4", OReadData1, OWriteCount);
        end
    endtask

    task automatic test_back_to_back();
        drive(2'b01, 5'd12, 64'h1, 64'h0);
        IReadAddr2 = 5'd12;
        step();
        drive(2'b01, 5'd12, 64'h2, 64'h0);
        #1;
        checks++;
        if (OReadData2 !== 64'h2) begin
            errors++; $display("FAIL b2b_bypass got %0h want 2", OReadData2);
        end
        step();
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        #1;
        checks++;
        if (OReadData2 !== 64'h2 || OWriteCount !== 32'd6) begin
            errors++; $display("FAIL b2b_after got %0h cnt %0d want 2 cnt 6", OReadData2, OWriteCount);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge Clk);
        drive(2'b01, 5'd5, 64'h77, 64'h0);
        IReadAddr1 = 5'd5;
        IReadAddr2 = 5'd7;
        #1;
        RstN = 1'b0;
        #1;
        checks++;
        if (OReadData1 !== 64'd0 || OReadData2 !== 64'd0 || OWriteCount !== 32'd0 || OWriteEn !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear got %0h/%0h cnt %0d we %0b want 0/0 cnt 0 we 0",
                     OReadData1, OReadData2, OWriteCount, OWriteEn);
        end
        step();
        RstN = 1'b1;
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        #1;
        checks++;
        if (OReadData1 !== 64'd0 || OWriteCount !== 32'd0) begin
            errors++; $display("FAIL midrst_dropped got %0h cnt %0d want 0 cnt 0", OReadData1, OWriteCount);
        end
        drive(2'b01, 5'd5, 64'h77, 64'h0);
        step();
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        #1;
        checks++;
        if (OReadData1 !== 64'h77 || OWriteCount !== 32'd1) begin
            errors++; $display("FAIL midrst_first got %0h cnt %0d want 77 cnt 1", OReadData1, OWriteCount);
        end
    endtask

    task automatic test_wrap_zero_ordinary();
        @(negedge Clk);
        s_rst_n = 1'b1;
        IReadAddr1 = 5'd0;
        for (int i = 1; i <= 8; i++) begin
            drive(2'b01, 5'd0, 64'(i), 64'h0);
            #1;
            checks++;
            if (s_we !== 1'b1 || s_rd1 !== 64'(i)) begin
                errors++; $display("FAIL small_r0_bypass_%0d got we %0b data %0h want 1/%0h", i, s_we, s_rd1, i);
            end
            step();
        end
        drive(2'b00, 5'd0, 64'h0, 64'h0);
        #1;
        checks++;
        if (s_cnt !== 3'd0) begin
            errors++; $display("FAIL small_wrap got %0d want 0", s_cnt);
        end
        checks++;
        if (s_rd1 !== 64'd8) begin
            errors++; $display("FAIL small_r0_stored got %0h want 8", s_rd1);
        end
        checks++;
        if (OReadData1 !== 64'd0 || OWriteCount !== 32'd1) begin
            errors++; $display("FAIL main_r0_ignored got %0h cnt %0d want 0 cnt 1", OReadData1, OWriteCount);
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_write();
        test_bypass();
        test_zero_reg();
        test_back_to_back();
        test_mid_reset();
        test_wrap_zero_ordinary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
